// File: rtl/l15_arb_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : l15_arb_pkg
// Brief   : Shared types for the L1.5 request arbiter: requester IDs, FSM
//           states and the registered request-field bundle.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
package l15_arb_pkg;

   // Width of the outstanding-request counters and their external view.
   localparam int unsigned CNT_W  = 3;
   localparam int unsigned DATA_W = 64;

   // Requester identity; doubles as the transaction ID sent to the L1.5.
   typedef enum logic {
      REQ_IC = 1'b0,
      REQ_DC = 1'b1
   } req_id_e;

   // Arbiter FSM: IDLE picks a winner, HOLD presents it until accepted.
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      HOLD = 1'b1
   } arb_state_e;

   // Request fields captured at selection time (address kept separately
   // because its width is a module parameter).
   typedef struct packed {
      logic [4:0]        rtype;
      logic [2:0]        size;
      logic              nc;
      logic [DATA_W-1:0] data;
      req_id_e           tid;
   } req_fields_t;

   // Returns the requester that loses to the given winner.
   function automatic req_id_e other_req(input req_id_e id);
      return (id == REQ_IC) ? REQ_DC : REQ_IC;
   endfunction

endpackage : l15_arb_pkg
`default_nettype wire

// File: rtl/l15_outst_cnt.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : l15_outst_cnt
// Brief   : Saturating up/down counter tracking outstanding requests for one
//           requester. Simultaneous inc and dec cancel out.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module l15_outst_cnt
   import l15_arb_pkg::*;
#(
   parameter int unsigned CNT_WIDTH = CNT_W
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 inc_i,
   input  logic                 dec_i,
   input  logic [CNT_WIDTH-1:0] limit_i,
   output logic [CNT_WIDTH-1:0] count_o
);

   logic [CNT_WIDTH-1:0] count_d;
   logic [CNT_WIDTH-1:0] count_q;

   // Next count: move by one in the requested direction, clamped to [0, limit].
   always_comb begin
      count_d = count_q;
      if (inc_i && !dec_i) begin
         if (count_q < limit_i) begin
            count_d = count_q + CNT_WIDTH'(1);
         end
      end else if (dec_i && !inc_i) begin
         if (count_q != '0) begin
            count_d = count_q - CNT_WIDTH'(1);
         end
      end
   end

   // Count register with synchronous reset to zero.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule : l15_outst_cnt
`default_nettype wire

// File: rtl/l15_req_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : l15_req_arbiter
// Brief   : Round-robin arbiter merging instruction- and data-cache requests
//           onto a single L1.5 request port, with per-requester outstanding
//           limits and combinational response routing by transaction ID.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module l15_req_arbiter
   import l15_arb_pkg::*;
#(
   parameter int unsigned MAX_OUTST = 2,
   parameter int unsigned ADDR_W    = 40
) (
   input  logic              clk_i,
   input  logic              rst_i,

   input  logic              ic_req_val_i,
   input  logic [4:0]        ic_req_type_i,
   input  logic [ADDR_W-1:0] ic_req_addr_i,
   input  logic [2:0]        ic_req_size_i,
   input  logic              ic_req_nc_i,
   output logic              ic_req_ack_o,

   input  logic              dc_req_val_i,
   input  logic [4:0]        dc_req_type_i,
   input  logic [ADDR_W-1:0] dc_req_addr_i,
   input  logic [2:0]        dc_req_size_i,
   input  logic              dc_req_nc_i,
   input  logic [63:0]       dc_req_data_i,
   output logic              dc_req_ack_o,

   output logic              l15_val_o,
   output logic [4:0]        l15_type_o,
   output logic [ADDR_W-1:0] l15_addr_o,
   output logic [2:0]        l15_size_o,
   output logic              l15_nc_o,
   output logic [63:0]       l15_data_o,
   output logic              l15_tid_o,
   input  logic              l15_ack_i,
   input  logic              l15_header_ack_i,

   input  logic              l15_rtrn_val_i,
   input  logic              l15_rtrn_tid_i,
   input  logic [3:0]        l15_rtrn_type_i,
   input  logic [127:0]      l15_rtrn_data_i,

   output logic              ic_rtrn_val_o,
   output logic              dc_rtrn_val_o,
   output logic [3:0]        rtrn_type_o,
   output logic [127:0]      rtrn_data_o,
   output logic [2:0]        ic_outst_o,
   output logic [2:0]        dc_outst_o,
   output logic              busy_o
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_OUTST);

   arb_state_e        state_d, state_q;
   req_id_e           rr_d, rr_q;
   req_fields_t       req_d, req_q;
   logic [ADDR_W-1:0] addr_d, addr_q;

   logic              ic_elig, dc_elig;
   req_id_e           win;
   logic              ic_ack_raw, dc_ack_raw;
   logic              ic_ack, dc_ack;
   logic              ic_rtrn, dc_rtrn;
   logic [CNT_W-1:0]  ic_cnt, dc_cnt;

   // Header acceptance is not used; only the full ack retires a request.
   logic              unused_hdr_ack;
   assign unused_hdr_ack = l15_header_ack_i;

   // Arbitration and hand-off: pick a winner in IDLE, hold it until acked.
   always_comb begin
      state_d    = state_q;
      rr_d       = rr_q;
      req_d      = req_q;
      addr_d     = addr_q;
      win        = REQ_IC;
      ic_ack_raw = 1'b0;
      dc_ack_raw = 1'b0;

      ic_elig = ic_req_val_i && (ic_cnt < LIMIT);
      dc_elig = dc_req_val_i && (dc_cnt < LIMIT);

      unique case (state_q)
         IDLE: begin
            if (ic_elig || dc_elig) begin
               // A full or idle requester forfeits its round-robin turn.
               if (ic_elig && (!dc_elig || (rr_q == REQ_IC))) begin
                  win = REQ_IC;
               end else begin
                  win = REQ_DC;
               end
               if (win == REQ_IC) begin
                  req_d.rtype = ic_req_type_i;
                  req_d.size  = ic_req_size_i;
                  req_d.nc    = ic_req_nc_i;
                  req_d.data  = '0;
                  req_d.tid   = REQ_IC;
                  addr_d      = ic_req_addr_i;
               end else begin
                  req_d.rtype = dc_req_type_i;
                  req_d.size  = dc_req_size_i;
                  req_d.nc    = dc_req_nc_i;
                  req_d.data  = dc_req_data_i;
                  req_d.tid   = REQ_DC;
                  addr_d      = dc_req_addr_i;
               end
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (l15_ack_i) begin
               if (req_q.tid == REQ_IC) begin
                  ic_ack_raw = 1'b1;
               end else begin
                  dc_ack_raw = 1'b1;
               end
               rr_d    = other_req(req_q.tid);
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // FSM, round-robin pointer and registered request fields.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         rr_q    <= REQ_IC;
         req_q   <= '0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         req_q   <= req_d;
         addr_q  <= addr_d;
      end
   end

   // Acks and routed returns are forced low while reset is held so a
   // request caught in HOLD is dropped without a stray handshake.
   assign ic_ack  = ic_ack_raw && !rst_i;
   assign dc_ack  = dc_ack_raw && !rst_i;
   assign ic_rtrn = l15_rtrn_val_i && (l15_rtrn_tid_i == REQ_IC) && !rst_i;
   assign dc_rtrn = l15_rtrn_val_i && (l15_rtrn_tid_i == REQ_DC) && !rst_i;

   l15_outst_cnt #(
      .CNT_WIDTH (CNT_W)
   ) u_ic_cnt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .inc_i   (ic_ack),
      .dec_i   (ic_rtrn),
      .limit_i (LIMIT),
      .count_o (ic_cnt)
   );

   l15_outst_cnt #(
      .CNT_WIDTH (CNT_W)
   ) u_dc_cnt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .inc_i   (dc_ack),
      .dec_i   (dc_rtrn),
      .limit_i (LIMIT),
      .count_o (dc_cnt)
   );

   assign ic_req_ack_o  = ic_ack;
   assign dc_req_ack_o  = dc_ack;

   assign l15_val_o     = (state_q == HOLD) && !rst_i;
   assign l15_type_o    = req_q.rtype;
   assign l15_addr_o    = addr_q;
   assign l15_size_o    = req_q.size;
   assign l15_nc_o      = req_q.nc;
   assign l15_data_o    = req_q.data;
   assign l15_tid_o     = req_q.tid;

   assign ic_rtrn_val_o = ic_rtrn;
   assign dc_rtrn_val_o = dc_rtrn;
   assign rtrn_type_o   = l15_rtrn_type_i;
   assign rtrn_data_o   = l15_rtrn_data_i;

   assign ic_outst_o    = ic_cnt;
   assign dc_outst_o    = dc_cnt;
   assign busy_o        = !rst_i && ((state_q == HOLD) || (ic_cnt != '0) || (dc_cnt != '0));

endmodule : l15_req_arbiter
`default_nettype wire

// File: doc/l15_req_arbiter.md
L15_REQ_ARBITER -- requirements
Module: l15_req_arbiter

Interface
REQ-001 SHALL have parameter MAX_OUTST, default 2, giving the maximum outstanding requests per requester (range 1..7).
REQ-002 SHALL have parameter ADDR_W, default 40, giving the physical address width.
REQ-003 SHALL have ports: clk_i in 1, single clock; rst_i in 1, reset that is synchronous and active-high.
REQ-004 SHALL have ports: ic_req_val_i in 1; ic_req_type_i in 5; ic_req_addr_i in ADDR_W; ic_req_size_i in 3; ic_req_nc_i in 1; ic_req_ack_o out 1 (instruction requester).
REQ-005 SHALL have ports: dc_req_val_i in 1; dc_req_type_i in 5; dc_req_addr_i in ADDR_W; dc_req_size_i in 3; dc_req_nc_i in 1; dc_req_data_i in 64; dc_req_ack_o out 1 (data requester).
REQ-006 SHALL have ports: l15_val_o out 1; l15_type_o out 5; l15_addr_o out ADDR_W; l15_size_o out 3; l15_nc_o out 1; l15_data_o out 64; l15_tid_o out 1; l15_ack_i in 1; l15_header_ack_i in 1.
REQ-007 SHALL have ports: l15_rtrn_val_i in 1; l15_rtrn_tid_i in 1; l15_rtrn_type_i in 4; l15_rtrn_data_i in 128.
REQ-008 SHALL have ports: ic_rtrn_val_o out 1; dc_rtrn_val_o out 1; rtrn_type_o out 4; rtrn_data_o out 128; ic_outst_o out 3; dc_outst_o out 3; busy_o out 1.

Function
REQ-009 SHALL implement FSM states IDLE and HOLD.
REQ-010 SHALL, in IDLE, select among requesters with val=1 and outstanding count < MAX_OUTST, using a round-robin pointer (rr: 0=ic, 1=dc) that gives priority to the requester rr names.
REQ-011 SHALL, on a selection in IDLE, register the winner's fields into output registers and move to HOLD on the next cycle.
REQ-012 SHALL drive l15_val_o=1 from the registered fields while in HOLD.
REQ-013 SHALL drive l15_tid_o with the winner ID: 0=ic, 1=dc.
REQ-014 SHALL drive l15_data_o=0 for ic grants.
REQ-015 SHALL keep all l15_* outputs stable in HOLD until l15_ack_i=1; l15_header_ack_i SHALL be ignored for acceptance.
REQ-016 SHALL, on l15_ack_i=1 in HOLD, pulse the winner's *_req_ack_o for 1 cycle in the same cycle, increment the winner's outstanding count, flip rr to the non-winner, and return to IDLE.
REQ-017 SHALL give a minimum issue interval of 2 cycles per request: IDLE select, then HOLD ack.
REQ-018 SHALL require requesters to keep val and fields stable until their ack; dropping val while not granted SHALL be legal and cause no grant.
REQ-019 SHALL route responses combinationally: when l15_rtrn_val_i=1, tid 0 -> ic_rtrn_val_o=1, tid 1 -> dc_rtrn_val_o=1; rtrn_type_o and rtrn_data_o SHALL pass through.
REQ-020 SHALL, on each routed response, decrement that requester's outstanding count.
REQ-021 SHALL, when a response and an ack for the same requester occur in one cycle, leave that count unchanged.
REQ-022 SHALL saturate counts at 0 and at MAX_OUTST and never wrap; a response arriving with count 0 SHALL be routed with the count held at 0.
REQ-023 SHALL not grant a requester whose count equals MAX_OUTST; the other requester SHALL be granted regardless of rr.
REQ-024 SHALL drive busy_o=1 in HOLD or when either count is nonzero.
REQ-025 SHALL drive ic_outst_o and dc_outst_o with the current counts, zero-extended to 3 bits.

Reset
REQ-026 SHALL, on rst_i=1 at a clk_i edge, set state=IDLE, rr=0, both counts=0, and all registered l15_* outputs=0.
REQ-027 SHALL hold l15_val_o, both *_req_ack_o and busy_o at 0 during reset.
REQ-028 SHALL drop a request in HOLD when reset is asserted mid-operation; no ack is issued and the request SHALL not be replayed.
REQ-029 SHALL keep routed return outputs gated to 0 while rst_i=1.

Structure
REQ-030 SHALL place the requester ID enum (REQ_IC=0, REQ_DC=1), the FSM state enum and the request-field struct in a shared package, l15_arb_pkg.
REQ-031 SHALL instantiate one sub-module, l15_outst_cnt (saturating up/down counter with inc, dec, limit and count ports), once per requester.

Verification
REQ-032 SHALL cover: ic and dc val=1 together after reset -> ic granted first (tid 0), dc granted in the next IDLE (tid 1).
REQ-033 SHALL cover: l15_ack_i held 0 for 5 cycles in HOLD -> l15_addr_o stable for all 5 cycles, ack pulses exactly once.
REQ-034 SHALL cover: MAX_OUTST=2, 2 ic requests acked with no responses -> ic_outst_o=2, a third ic request blocked, a dc request granted.
REQ-035 SHALL cover: response with tid 1 and an ack for dc in the same cycle -> dc_outst_o unchanged, dc_rtrn_val_o=1.
REQ-036 SHALL cover: rst_i asserted during HOLD -> next cycle l15_val_o=0, counts=0, rr=0, no ack pulse.
REQ-037 SHALL cover: response with tid 0 while ic_outst_o=0 -> ic_rtrn_val_o=1, count remains 0.
